// File: rtl/expr_tx.sv
// Serialises a captured BCD expression "d (op d)*" as ASCII bytes over a valid/ready stream.
// One byte per accepted transfer, followed by a single-cycle done pulse.
module expr_tx #(
  parameter logic [7:0] PLUS_CHAR = 8'h2B,
  parameter logic [7:0] MUL_CHAR  = 8'h2A
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        start,
  input  logic [2:0]  n_ops,
  input  logic [31:0] digits,
  input  logic [6:0]  ops,
  input  logic        out_ready,
  output logic [7:0]  out,
  output logic        out_valid,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIG  = 2'd1,
    OP   = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] dig_q, dig_d;
  logic [6:0]  ops_q, ops_d;
  logic [7:0]  out_q, out_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        xfer;
  logic        bad_req;
  logic [2:0]  k_inc;
  logic [3:0]  nxt_dig;

  // Stream handshake: a byte moves when out_valid and out_ready are both high
  // at a rising edge; while out_valid is high and no transfer happens, out,
  // out_valid and out_last are held unchanged.
  assign xfer    = valid_q & out_ready;
  assign k_inc   = k_q + 3'd1;
  assign nxt_dig = dig_q[{k_inc, 2'b00} +: 4];

  // Only terms 0..n_ops are checked; nibbles beyond the operator count are don't-care.
  always_comb begin
    bad_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) <= n_ops) && (digits[4*i +: 4] > 4'd9)) begin
        bad_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    dig_d   = dig_q;
    ops_d   = ops_q;
    out_d   = out_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = n_ops;
          dig_d = digits;
          ops_d = ops;
          k_d   = 3'd0;
          err_d = bad_req;
          if (!bad_req) begin
            state_d = DIG;
            out_d   = 8'h30 + {4'h0, digits[3:0]};
            valid_d = 1'b1;
            last_d  = (n_ops == 3'd0);
          end
        end
      end
      DIG: begin
        if (xfer) begin
          if (k_q == n_q) begin
            state_d = FIN;
            out_d   = 8'h00;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = OP;
            out_d   = ops_q[k_q] ? MUL_CHAR : PLUS_CHAR;
            last_d  = 1'b0;
          end
        end
      end
      OP: begin
        if (xfer) begin
          state_d = DIG;
          k_d     = k_inc;
          out_d   = 8'h30 + {4'h0, nxt_dig};
          last_d  = (k_inc == n_q);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      n_q     <= 3'd0;
      dig_q   <= 32'd0;
      ops_q   <= 7'd0;
      out_q   <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      dig_q   <= dig_d;
      ops_q   <= ops_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule
